// File: rtl/scl_sparecell_monitor.sv
// Spare-cell tie-low monitor: synchronizes LO nets, filters sustained highs,
// and records sticky per-cell faults with a saturating event counter and IRQ.
module scl_sparecell_monitor #(
    parameter int NUM_CELLS     = 4,
    parameter int FILTER_LEN    = 3,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 enable_i,
    input  logic [NUM_CELLS-1:0] lo_i,
    input  logic                 clear_i,
    output logic [NUM_CELLS-1:0] fault_mask_o,
    output logic                 fault_o,
    output logic [CNT_W-1:0]     err_count_o,
    output logic                 irq_o,
    output logic                 busy_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int PW = $clog2(NUM_CELLS + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [FW-1:0]    FLT_MAX     = FW'(FILTER_LEN);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, MONITOR} state_t;

    state_t               state_q;
    logic [7:0]           settle_q;
    logic                 busy_q;
    logic [NUM_CELLS-1:0] s1_q, s2_q;
    logic [NUM_CELLS-1:0] hit, new_set;
    logic [NUM_CELLS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base;
    logic [PW-1:0]        pop;
    logic [SW-1:0]        sum;
    logic                 fault_q, pend_q, irq_q;
    logic                 active;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            settle_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (enable_i) begin
                        state_q  <= SETTLE;
                        settle_q <= '0;
                    end
                end
                SETTLE: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_q <= MONITOR;
                        busy_q  <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                MONITOR: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= lo_i;
            s2_q <= s1_q;
        end
    end

    // Filters stop on the same edge enable drops, so a disable never completes a fault.
    assign active = (state_q == MONITOR) && enable_i;

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        logic [FW-1:0] flt_q;
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i || !active || !s2_q[g]) flt_q <= '0;
            else if (flt_q != FLT_MAX)           flt_q <= flt_q + FW'(1);
        end
        assign hit[g] = active && s2_q[g] && (flt_q == FLT_MAX - FW'(1));
    end

    // A clear in the same cycle lets every completing filter register as a fresh event.
    always_comb begin
        new_set  = clear_i ? hit : (hit & ~mask_q);
        mask_d   = clear_i ? new_set : (mask_q | new_set);
        cnt_base = clear_i ? '0 : cnt_q;
        pop      = '0;
        for (int i = 0; i < NUM_CELLS; i++) pop = pop + PW'(new_set[i]);
        sum   = SW'(cnt_base) + SW'(pop);
        cnt_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mask_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            fault_q <= |mask_d;
            cnt_q   <= cnt_d;
            pend_q  <= |new_set;
            irq_q   <= pend_q;
        end
    end

    assign fault_mask_o = mask_q;
    assign fault_o      = fault_q;
    assign err_count_o  = cnt_q;
    assign irq_o        = irq_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_scl_sparecell_monitor.sv
// Bench for scl_sparecell_monitor: two instances (8-bit and 2-bit counters)
// share stimulus and are compared against a run-length reference model.
module tb_scl_sparecell_monitor;
    localparam int SC = 8;
    localparam int FL = 3;

    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic [3:0] lo;
    logic [3:0] mask_a, mask_b;
    logic       fault_a, fault_b, irq_a, irq_b, busy_a, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    scl_sparecell_monitor #(.NUM_CELLS(4), .FILTER_LEN(FL), .SETTLE_CYCLES(SC), .CNT_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en), .lo_i(lo), .clear_i(clr),
        .fault_mask_o(mask_a), .fault_o(fault_a), .err_count_o(cnt_a),
        .irq_o(irq_a), .busy_o(busy_a));

    scl_sparecell_monitor #(.NUM_CELLS(4), .FILTER_LEN(FL), .SETTLE_CYCLES(SC), .CNT_W(2)) dut_s (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en), .lo_i(lo), .clear_i(clr),
        .fault_mask_o(mask_b), .fault_o(fault_b), .err_count_o(cnt_b),
        .irq_o(irq_b), .busy_o(busy_b));

    int n_chk = 0;
    int n_fail = 0;
    int irq_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: monitoring starts once enable has been high for SC+2
    // consecutive edges; a fault is the moment a delayed-input high run hits FL.
    int         en_run, m_raw;
    int         hi_run [4];
    logic [3:0] s1m, s2m, m_mask;
    logic       m_pend, m_irq;

    task automatic model_step(input logic r, input logic e, input logic c, input logic [3:0] l);
        logic [3:0] ns;
        bit act;
        if (r) begin
            en_run = 0; m_raw = 0; s1m = '0; s2m = '0; m_mask = '0; m_pend = 1'b0; m_irq = 1'b0;
            for (int i = 0; i < 4; i++) hi_run[i] = 0;
        end else begin
            act = (en_run >= SC + 2) && e;
            ns  = '0;
            for (int i = 0; i < 4; i++) begin
                if (act && s2m[i]) begin
                    hi_run[i]++;
                    if (hi_run[i] == FL && (c || !m_mask[i])) ns[i] = 1'b1;
                end else begin
                    hi_run[i] = 0;
                end
            end
            m_irq  = m_pend;
            m_pend = |ns;
            if (c) begin m_mask = ns; m_raw = $countones(ns); end
            else   begin m_mask = m_mask | ns; m_raw = m_raw + $countones(ns); end
            s2m = s1m;
            s1m = l;
            en_run = e ? en_run + 1 : 0;
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic c, input logic [3:0] l);
        bit mb;
        rst = r; en = e; clr = c; lo = l;
        @(posedge clk);
        model_step(r, e, c, l);
        #1;
        mb = (en_run >= SC + 2);
        irq_cnt += int'(irq_a);
        chk("mask_a",  32'(mask_a),  32'(m_mask));
        chk("fault_a", 32'(fault_a), 32'(|m_mask));
        chk("cnt_a",   32'(cnt_a),   (m_raw > 255) ? 32'd255 : 32'(m_raw));
        chk("irq_a",   32'(irq_a),   32'(m_irq));
        chk("busy_a",  32'(busy_a),  32'(mb));
        chk("mask_b",  32'(mask_b),  32'(m_mask));
        chk("fault_b", 32'(fault_b), 32'(|m_mask));
        chk("cnt_b",   32'(cnt_b),   (m_raw > 3) ? 32'd3 : 32'(m_raw));
        chk("irq_b",   32'(irq_b),   32'(m_irq));
        chk("busy_b",  32'(busy_b),  32'(mb));
    endtask

    task automatic run(input int n, input logic e, input logic [3:0] l);
        for (int i = 0; i < n; i++) cycle(1'b0, e, 1'b0, l);
    endtask

    typedef struct {
        int         reps;
        logic       rst, en, clr;
        logic [3:0] lo;
        logic [3:0] mask;
        logic [7:0] cnt;
        logic       irq, busy;
    } vec_t;

    function automatic vec_t mk(int reps, logic r, logic e, logic c, logic [3:0] l,
                                logic [3:0] m, logic [7:0] n, logic i, logic b);
        vec_t v;
        v.reps = reps; v.rst = r; v.en = e; v.clr = c; v.lo = l;
        v.mask = m; v.cnt = n; v.irq = i; v.busy = b;
        return v;
    endfunction

    localparam int NV = 15;
    vec_t       tbl [NV];
    logic [3:0] lo_r;
    logic       en_r, clr_r, rst_r;

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; lo = '0;
        for (int i = 0; i < 4; i++) hi_run[i] = 0;

        // reset, settle, single fault with IRQ, hold, clear, refault, reset mid-fault
        tbl[0]  = mk(2,  1, 0, 0, 4'h0, 4'h0, 8'd0, 0, 0);
        tbl[1]  = mk(9,  0, 1, 0, 4'h0, 4'h0, 8'd0, 0, 0);
        tbl[2]  = mk(1,  0, 1, 0, 4'h0, 4'h0, 8'd0, 0, 1);
        tbl[3]  = mk(4,  0, 1, 0, 4'h4, 4'h0, 8'd0, 0, 1);
        tbl[4]  = mk(1,  0, 1, 0, 4'h4, 4'h4, 8'd1, 0, 1);
        tbl[5]  = mk(1,  0, 1, 0, 4'h4, 4'h4, 8'd1, 1, 1);
        tbl[6]  = mk(1,  0, 1, 0, 4'h4, 4'h4, 8'd1, 0, 1);
        tbl[7]  = mk(20, 0, 1, 0, 4'h4, 4'h4, 8'd1, 0, 1);
        tbl[8]  = mk(1,  0, 1, 1, 4'h4, 4'h0, 8'd0, 0, 1);
        tbl[9]  = mk(5,  0, 1, 0, 4'h4, 4'h0, 8'd0, 0, 1);
        tbl[10] = mk(3,  0, 1, 0, 4'h0, 4'h0, 8'd0, 0, 1);
        tbl[11] = mk(5,  0, 1, 0, 4'h4, 4'h4, 8'd1, 0, 1);
        tbl[12] = mk(1,  1, 1, 0, 4'hF, 4'h0, 8'd0, 0, 0);
        tbl[13] = mk(5,  1, 1, 0, 4'hF, 4'h0, 8'd0, 0, 0);
        tbl[14] = mk(3,  0, 0, 0, 4'h0, 4'h0, 8'd0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) cycle(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].lo);
            chk($sformatf("tbl%0d_mask", i),  32'(mask_a),  32'(tbl[i].mask));
            chk($sformatf("tbl%0d_fault", i), 32'(fault_a), 32'(|tbl[i].mask));
            chk($sformatf("tbl%0d_cnt", i),   32'(cnt_a),   32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_cnt2", i),  32'(cnt_b),   32'(tbl[i].cnt[1:0]));
            chk($sformatf("tbl%0d_irq", i),   32'(irq_a),   32'(tbl[i].irq));
            chk($sformatf("tbl%0d_busy", i),  32'(busy_a),  32'(tbl[i].busy));
        end

        // glitch rejection: 2 high / 1 low never completes a 3-sample filter
        run(10, 1'b1, 4'h0);
        irq_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            run(2, 1'b1, 4'h1);
            run(1, 1'b1, 4'h0);
        end
        run(3, 1'b1, 4'h0);
        chk("glitch_mask", 32'(mask_a), 32'h0);
        chk("glitch_cnt",  32'(cnt_a),  32'h0);
        chk("glitch_irq",  32'(irq_cnt), 32'd0);

        // simultaneous faults raise one IRQ pulse
        irq_cnt = 0;
        run(7, 1'b1, 4'hB);
        chk("simul_mask", 32'(mask_a), 32'hB);
        chk("simul_cnt",  32'(cnt_a),  32'd3);
        chk("simul_irq",  32'(irq_cnt), 32'd1);

        // clear collides with a completing filter: the new fault wins
        cycle(1'b0, 1'b1, 1'b1, 4'h0);
        run(3, 1'b1, 4'h0);
        run(6, 1'b1, 4'h1);
        chk("coll_pre_mask", 32'(mask_a), 32'h1);
        chk("coll_pre_cnt",  32'(cnt_a),  32'd1);
        irq_cnt = 0;
        run(4, 1'b1, 4'h9);
        cycle(1'b0, 1'b1, 1'b1, 4'h9);
        chk("coll_mask", 32'(mask_a), 32'h8);
        chk("coll_cnt",  32'(cnt_a),  32'd1);
        run(1, 1'b1, 4'h9);
        chk("coll_irq",  32'(irq_a), 32'd1);
        run(3, 1'b1, 4'h9);
        chk("coll_irq_once", 32'(irq_cnt), 32'd1);

        // saturation of the 2-bit counter
        cycle(1'b0, 1'b1, 1'b1, 4'h0);
        run(3, 1'b1, 4'h0);
        run(6, 1'b1, 4'hF);
        chk("sat_cnt_a", 32'(cnt_a), 32'd4);
        chk("sat_cnt_b", 32'(cnt_b), 32'd3);
        cycle(1'b0, 1'b1, 1'b1, 4'hF);
        run(3, 1'b1, 4'h0);
        run(6, 1'b1, 4'hF);
        chk("sat2_cnt_a", 32'(cnt_a), 32'd4);
        chk("sat2_cnt_b", 32'(cnt_b), 32'd3);

        // disable mid-filter keeps the mask, then re-enable needs full settle + filter
        cycle(1'b0, 1'b1, 1'b1, 4'h0);
        run(3, 1'b1, 4'h0);
        run(6, 1'b1, 4'h2);
        run(4, 1'b1, 4'h3);
        run(1, 1'b0, 4'h3);
        chk("dis_busy", 32'(busy_a), 32'd0);
        chk("dis_mask", 32'(mask_a), 32'h2);
        run(1, 1'b0, 4'h3);
        run(12, 1'b1, 4'h3);
        chk("reen_early_mask", 32'(mask_a), 32'h2);
        run(1, 1'b1, 4'h3);
        chk("reen_mask", 32'(mask_a), 32'h3);

        // randomized traffic against the model
        lo_r = '0; en_r = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) lo_r[b] = ~lo_r[b];
            if (en_r) en_r = ($urandom_range(0, 99) != 0);
            else      en_r = ($urandom_range(0, 3) == 0);
            clr_r = ($urandom_range(0, 39) == 0);
            rst_r = ($urandom_range(0, 599) == 0);
            cycle(rst_r, en_r, clr_r, lo_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/scl_sparecell_monitor.md
# scl_sparecell_monitor

Synchronous monitor for spare-cell tie-low outputs (`LO`) in the SCL standard-cell flow. It samples up to `NUM_CELLS` spare-cell `LO` nets and flags any net held high for `FILTER_LEN` consecutive samples as a tie-off fault. It keeps per-cell sticky fault bits, a saturating fault-event counter and a one-cycle interrupt pulse. It sits in the housekeeping area beside the spare-cell macros, so post-ECO silicon and gate-level simulation can confirm that rewired spare cells left the tie nets intact.

## Interface
Parameters:
- `NUM_CELLS`, default 4: number of monitored `LO` nets, 1..32.
- `FILTER_LEN`, default 3: consecutive high samples needed to declare a fault, 1..15.
- `SETTLE_CYCLES`, default 8: cycles ignored after enable before monitoring starts, 0..255.
- `CNT_W`, default 8: width of the fault-event counter.

Ports:
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_i`, in, 1: **reset is synchronous and active-high**.
- `enable_i`, in, 1: monitor enable, level.
- `lo_i`, in, `NUM_CELLS`: spare-cell `LO` nets. Asynchronous static levels.
- `clear_i`, in, 1: one-cycle pulse that clears the sticky bits and the counter.
- `fault_mask_o`, out, `NUM_CELLS`: sticky per-cell fault bits.
- `fault_o`, out, 1: OR-reduction of `fault_mask_o`, registered.
- `err_count_o`, out, `CNT_W`: saturating count of fault events.
- `irq_o`, out, 1: one-cycle pulse on any newly set fault bit.
- `busy_o`, out, 1: high in the MONITOR state.

## Operation
- Input path: each `lo_i` bit passes through a 2-flop synchronizer (`s1`, `s2`). The synchronizer runs in all states and is cleared by reset.
- State machine:
  - IDLE → SETTLE when `enable_i`=1.
  - SETTLE counts `SETTLE_CYCLES`, then moves to MONITOR. With `SETTLE_CYCLES`=0, SETTLE lasts exactly 1 cycle.
  - SETTLE and MONITOR return to IDLE on the next edge whenever `enable_i`=0.
- Per-cell filter counter, width ceil(log2(`FILTER_LEN`+1)):
  - Active only in MONITOR.
  - Increments while `s2`=1.
  - Resets to 0 on `s2`=0, and in IDLE or SETTLE.
  - Saturates at `FILTER_LEN`.
- Fault set: on the edge where a cell's counter goes from `FILTER_LEN`-1 to `FILTER_LEN` and its mask bit is 0, that mask bit is set. A cell produces at most one event per clear.
- Counter update: `err_count_o` += popcount(newly set bits) in that cycle, saturating at 2^`CNT_W`-1. No wrap.
- `irq_o`=1 in the cycle after any bit is newly set, for exactly one cycle.
- `fault_o` = |`fault_mask_o`, registered together with the mask, so both change on the same edge.
- `clear_i`: clears the mask and the counter on the next edge; the filter counters are kept.
  - If a new fault sets in the same cycle as `clear_i`, the new fault wins: that bit is 1, the counter equals the number of new faults, and `irq_o` pulses.
  - A cell still high after clear does not re-fault while its filter counter is saturated. It re-faults only after going low and then high for `FILTER_LEN` more samples.
- Disable (`enable_i`=0): the filter counters clear. The mask and counter are retained.
- Reset mid-operation: all state returns to reset values on that edge, regardless of any in-flight fault.

## Timing
- Reset values: `fault_mask_o`=0, `fault_o`=0, `err_count_o`=0, `irq_o`=0, `busy_o`=0, FSM=IDLE, synchronizers and filter counters 0.
- Enable latency: `enable_i` sampled high at edge 0 → SETTLE after edge 0 → MONITOR after edge `SETTLE_CYCLES`+1 (`busy_o`=1 from then).
- Fault latency in MONITOR, with `lo_i` high from before edge 0 and MONITOR already active:
  - `s1` is high after edge 0.
  - `s2` is high after edge 1.
  - The filter reaches `FILTER_LEN` at edge `FILTER_LEN`+1.
  - The mask bit, `fault_o` and `err_count_o` update after edge `FILTER_LEN`+1.
  - `irq_o` is high for the cycle following edge `FILTER_LEN`+2.
- A single-cycle glitch on `lo_i` shorter than `FILTER_LEN` samples never sets a fault.
- All outputs are registered and there are no combinational input→output paths.

## Test plan
- **Reset:** assert `wb_rst_i` with `lo_i`=4'hF in MONITOR → all outputs 0 after the reset edge and FSM in IDLE; hold 5 cycles with reset high → still 0.
- **Single fault:** defaults; enable, wait until `busy_o`=1; drive `lo_i`=4'b0100 → `fault_mask_o`=4'b0100, `err_count_o`=1 after edge 4 relative to the `lo_i` change; `irq_o` high exactly one cycle; holding `lo_i` high 20 more cycles → no further increment.
- **Glitch rejection:** `lo_i[0]` high for 2 cycles, low 1 cycle, repeated 10 times → mask 0, count 0, no `irq_o`.
- **Simultaneous faults:** `lo_i` from 0 to 4'b1011 in one cycle → mask 4'b1011, `err_count_o`=3, and a single one-cycle `irq_o`.
- **Clear/fault collision:** mask 4'b0001, count 1; pulse `clear_i` on the same cycle `lo_i[3]` completes its filter → mask 4'b1000, count 1, `irq_o` pulses.
- **Saturation and disable:** with `CNT_W`=2 and `NUM_CELLS`=4:
  - Drive 4 faults, clear, then drop and raise `lo_i` to re-fault all 4 cells → `err_count_o` stays 3.
  - Deassert `enable_i` mid-filter (count 2 of 3) → FSM reaches IDLE next edge, filter counters clear, mask retained.
  - Re-enable → fault needs the full `SETTLE_CYCLES`+`FILTER_LEN` again.
